// File: rtl/fault_campaign_checker.sv
// Fault-injection campaign checker: accepts one stuck-at command at a time, holds the fault
// active for one settle cycle plus a compare window, and reports the first output mismatch.
module fault_campaign_checker #(
    parameter int WIDTH  = 16,
    parameter int IDXW   = 8,
    parameter int WINDOW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IDXW-1:0]   cmd_index,
    input  logic              cmd_polarity,
    output logic              inj_en,
    output logic [IDXW-1:0]   inj_index,
    output logic              inj_polarity,
    input  logic [WIDTH-1:0]  dut_y,
    input  logic [WIDTH-1:0]  gold_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_detected,
    output logic [IDXW-1:0]   res_index,
    output logic [7:0]        res_cycle
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [7:0] LAST_CYCLE = 8'(WINDOW - 1);

    logic [1:0]      r_state;
    logic [7:0]      r_count;
    logic [IDXW-1:0] r_inj_index;
    logic            r_inj_polarity;
    logic            r_res_detected;
    logic [IDXW-1:0] r_res_index;
    logic [7:0]      r_res_cycle;

    logic            w_accept;
    logic            w_mismatch;

    // cmd_ready is gated by rst so it drops asynchronously together with the state reset.
    assign cmd_ready    = (r_state == S_IDLE) && !rst;
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_mismatch   = (dut_y != gold_y);

    assign inj_en       = (r_state == S_SETTLE) || (r_state == S_RUN);
    assign res_valid    = (r_state == S_REPORT);
    assign inj_index    = r_inj_index;
    assign inj_polarity = r_inj_polarity;
    assign res_detected = r_res_detected;
    assign res_index    = r_res_index;
    assign res_cycle    = r_res_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_inj_index    <= '0;
            r_inj_polarity <= 1'b0;
            r_res_detected <= 1'b0;
            r_res_index    <= '0;
            r_res_cycle    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_inj_index    <= cmd_index;
                        r_inj_polarity <= cmd_polarity;
                        r_state        <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_count <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // Result registers only change on entry to REPORT, so they stay stable there.
                    if (w_mismatch) begin
                        r_res_detected <= 1'b1;
                        r_res_cycle    <= r_count;
                        r_res_index    <= r_inj_index;
                        r_state        <= S_REPORT;
                    end else if (r_count == LAST_CYCLE) begin
                        r_res_detected <= 1'b0;
                        r_res_cycle    <= LAST_CYCLE;
                        r_res_index    <= r_inj_index;
                        r_state        <= S_REPORT;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
